// File: rtl/div_seq.sv
// ---------------------------------------------------------------------------
// div_seq -- iterative radix-2 restoring divider for the EX stage DIV/DIVU ops
//
// EX presents operands with a start strobe while o_div_ready is high.
// The block then runs W shift-subtract steps on operand magnitudes, applies
// the sign correction for truncating signed division, and pulses o_div_done
// for one cycle with o_quotient/o_remainder valid. A divisor of zero skips
// the iterations and returns zero for both results. i_annul (pipeline flush)
// abandons any in-flight division without a done pulse.
//
// Ports
//   clk          core clock, rising edge
//   i_rst_n      synchronous active-low reset
//   i_annul      pipeline flush, abandons current division
//   i_divstart   start strobe, honoured only while o_div_ready=1
//   i_divsigned  1 = signed (DIV), 0 = unsigned (DIVU)
//   i_dividend   dividend, W bits
//   i_divisor    divisor, W bits
//   o_div_ready  idle and able to accept a start
//   o_div_done   one-cycle result-valid pulse
//   o_quotient   quotient (to LO), held until the next done
//   o_remainder  remainder (to HI), held until the next done
//
// Optional build macro
//   DIV_EARLY_OUT_EN  when |dividend| < |divisor| the result (q=0,
//                     r=dividend) is produced without iterating.
// ---------------------------------------------------------------------------
module div_seq #(
   parameter int W     = 32,
   parameter int CNT_W = 6
) (
   input  logic         clk,
   input  logic         i_rst_n,
   input  logic         i_annul,
   input  logic         i_divstart,
   input  logic         i_divsigned,
   input  logic [W-1:0] i_dividend,
   input  logic [W-1:0] i_divisor,
   output logic         o_div_ready,
   output logic         o_div_done,
   output logic [W-1:0] o_quotient,
   output logic [W-1:0] o_remainder
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [W-1:0]     ZERO_W   = {W{1'b0}};

   // Two's complement negate when neg is set.
   function automatic logic [W-1:0] neg_if(input logic [W-1:0] v, input logic neg);
      logic [W-1:0] r;
      if (neg) begin
         r = ~v + {{(W-1){1'b0}}, 1'b1};
      end else begin
         r = v;
      end
      return r;
   endfunction

   state_t           state_r, state_nxt_s;
   logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
   logic [W-1:0]     rem_r, rem_nxt_s;
   logic [W-1:0]     quo_r, quo_nxt_s;
   logic [W-1:0]     dvs_r, dvs_nxt_s;
   logic             q_neg_r, q_neg_nxt_s;
   logic             r_neg_r, r_neg_nxt_s;
   logic [W-1:0]     quot_r, quot_nxt_s;
   logic [W-1:0]     rmd_r, rmd_nxt_s;
   logic             ready_r, done_r;

   logic [W-1:0]     abs_dvd_s, abs_dvs_s;
   logic [W:0]       rem_sh_s;
   logic             fits_s;
   logic [W-1:0]     rem_step_s, quo_step_s;

   // One restoring step; the shifted remainder is W+1 bits so the compare
   // cannot overflow. After subtraction the value is below the divisor, so
   // the low W bits of the difference are exact.
   always_comb begin
      abs_dvd_s = neg_if(i_dividend, i_divsigned & i_dividend[W-1]);
      abs_dvs_s = neg_if(i_divisor,  i_divsigned & i_divisor[W-1]);
      rem_sh_s  = {rem_r, quo_r[W-1]};
      fits_s    = (rem_sh_s >= {1'b0, dvs_r});
      if (fits_s) begin
         rem_step_s = rem_sh_s[W-1:0] - dvs_r;
      end else begin
         rem_step_s = rem_sh_s[W-1:0];
      end
      quo_step_s = {quo_r[W-2:0], fits_s};
   end

   // Next-state and datapath decisions; flush overrides every transition.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      rem_nxt_s   = rem_r;
      quo_nxt_s   = quo_r;
      dvs_nxt_s   = dvs_r;
      q_neg_nxt_s = q_neg_r;
      r_neg_nxt_s = r_neg_r;
      quot_nxt_s  = quot_r;
      rmd_nxt_s   = rmd_r;
      if (i_annul) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (i_divstart) begin
                  if (i_divisor == ZERO_W) begin
                     quot_nxt_s  = ZERO_W;
                     rmd_nxt_s   = ZERO_W;
                     state_nxt_s = ST_DONE;
`ifdef DIV_EARLY_OUT_EN
                  end else if (abs_dvd_s < abs_dvs_s) begin
                     quot_nxt_s  = ZERO_W;
                     rmd_nxt_s   = i_dividend;
                     state_nxt_s = ST_DONE;
`endif
                  end else begin
                     rem_nxt_s   = ZERO_W;
                     quo_nxt_s   = abs_dvd_s;
                     dvs_nxt_s   = abs_dvs_s;
                     q_neg_nxt_s = i_divsigned & (i_dividend[W-1] ^ i_divisor[W-1]);
                     r_neg_nxt_s = i_divsigned & i_dividend[W-1];
                     cnt_nxt_s   = CNT_ZERO;
                     state_nxt_s = ST_RUN;
                  end
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_RUN: begin
               rem_nxt_s = rem_step_s;
               quo_nxt_s = quo_step_s;
               cnt_nxt_s = cnt_r + CNT_ONE;
               if (cnt_r == CNT_LAST) begin
                  quot_nxt_s  = neg_if(quo_step_s, q_neg_r);
                  rmd_nxt_s   = neg_if(rem_step_s, r_neg_r);
                  state_nxt_s = ST_DONE;
               end else begin
                  state_nxt_s = ST_RUN;
               end
            end
            ST_DONE: begin
               state_nxt_s = ST_IDLE;
            end
            default: begin
               state_nxt_s = ST_IDLE;
            end
         endcase
      end
   end

   // FSM state register plus registered ready/done decoded from next state.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         state_r <= ST_IDLE;
         ready_r <= 1'b1;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         ready_r <= (state_nxt_s == ST_IDLE);
         done_r  <= (state_nxt_s == ST_DONE);
      end
   end

   // Datapath registers: working remainder/quotient, operands, results.
   always_ff @(posedge clk) begin
      if (!i_rst_n) begin
         cnt_r   <= CNT_ZERO;
         rem_r   <= ZERO_W;
         quo_r   <= ZERO_W;
         dvs_r   <= ZERO_W;
         q_neg_r <= 1'b0;
         r_neg_r <= 1'b0;
         quot_r  <= ZERO_W;
         rmd_r   <= ZERO_W;
      end else begin
         cnt_r   <= cnt_nxt_s;
         rem_r   <= rem_nxt_s;
         quo_r   <= quo_nxt_s;
         dvs_r   <= dvs_nxt_s;
         q_neg_r <= q_neg_nxt_s;
         r_neg_r <= r_neg_nxt_s;
         quot_r  <= quot_nxt_s;
         rmd_r   <= rmd_nxt_s;
      end
   end

   assign o_div_ready = ready_r;
   assign o_div_done  = done_r;
   assign o_quotient  = quot_r;
   assign o_remainder = rmd_r;

endmodule
